// File: rtl/ysyx_22051013_regfile_mp_sb_if.sv
// Register file / scoreboard bus: write ports, read ports, issue and flush
// controls, and the full busy vector.
// master = pipeline side (decode/issue + writeback), slave = register file.
interface ysyx_22051013_regfile_mp_sb_if #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned NRD  = 2,
    parameter int unsigned NWR  = 2
);
    logic [NWR-1:0]      wen;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic [NRD-1:0]      ren;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic                iss_en;
    logic [AW-1:0]       iss_rd;
    logic                flush;
    logic [NREG-1:0]     busy_vec;

    modport master (
        output wen, waddr, wdata, ren, raddr, iss_en, iss_rd, flush,
        input  rdata, rbusy, busy_vec
    );

    modport slave (
        input  wen, waddr, wdata, ren, raddr, iss_en, iss_rd, flush,
        output rdata, rbusy, busy_vec
    );
endinterface

// File: rtl/ysyx_22051013_regfile_mp_sb.sv
// Multi-port integer register file with per-register busy scoreboard for
// the dual-issue pipeline. Reads are combinational, writes and scoreboard
// updates happen on posedge clk. Register 0 reads as zero and is never busy.
// Optional macro YSYX_22051013_RF_BYPASS_EN forwards same-cycle write data
// to matching read ports.
module ysyx_22051013_regfile_mp_sb #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned NRD  = 2,
    parameter int unsigned NWR  = 2
) (
    input logic                            clk,
    input logic                            rst,
    ysyx_22051013_regfile_mp_sb_if.slave   rf
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Next register contents; a later write port overrides an earlier one.
    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < NWR; k++) begin
            if (rf.wen[k] && (rf.waddr[k*AW +: AW] != '0)) begin
                regs_d[rf.waddr[k*AW +: AW]] = rf.wdata[k*XLEN +: XLEN];
            end
        end
    end

    // Next scoreboard: flush clears all, else writeback clears, then issue sets.
    always_comb begin
        busy_d = busy_q;
        if (rf.flush) begin
            busy_d = '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (rf.wen[k] && (rf.waddr[k*AW +: AW] != '0)) begin
                    busy_d[rf.waddr[k*AW +: AW]] = 1'b0;
                end
            end
            if (rf.iss_en && (rf.iss_rd != '0)) begin
                busy_d[rf.iss_rd] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Combinational read ports; disabled, x0 and in-reset reads return zero.
    always_comb begin : rd_ports
        logic [AW-1:0] a;
        logic          hit;
        a        = '0;
        hit      = 1'b0;
        rf.rdata = '0;
        rf.rbusy = '0;
        for (int j = 0; j < NRD; j++) begin
            a   = rf.raddr[j*AW +: AW];
            hit = 1'b0;
            if (!rst && rf.ren[j] && (a != '0)) begin
                rf.rdata[j*XLEN +: XLEN] = regs_q[a];
                rf.rbusy[j]              = busy_q[a];
`ifdef YSYX_22051013_RF_BYPASS_EN
                for (int k = 0; k < NWR; k++) begin
                    if (rf.wen[k] && (rf.waddr[k*AW +: AW] == a)) begin
                        rf.rdata[j*XLEN +: XLEN] = rf.wdata[k*XLEN +: XLEN];
                        hit                      = 1'b1;
                    end
                end
                // Forwarded value is final unless a new producer issues to it now.
                if (hit && !(rf.iss_en && (rf.iss_rd == a))) begin
                    rf.rbusy[j] = 1'b0;
                end
`endif
            end
        end
    end

    assign rf.busy_vec = busy_q;

endmodule

// File: tb/tb_ysyx_22051013_regfile_mp_sb.sv
// Bench for the multi-port register file / scoreboard: directed scenarios
// followed by random traffic, checked against a behavioural model through
// an expectation queue and an independent monitor.
module tb_ysyx_22051013_regfile_mp_sb;

    localparam int unsigned XLEN = 64;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NRD  = 2;
    localparam int unsigned NWR  = 2;

    typedef struct packed {
        logic [NRD*XLEN-1:0] rdata;
        logic [NRD-1:0]      rbusy;
        logic [NREG-1:0]     bv;
        logic                chk_bv;
        logic [3:0]          phase;
    } exp_t;

    logic clk;
    logic rst;

    ysyx_22051013_regfile_mp_sb_if #(
        .XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .NWR(NWR)
    ) bus ();

    ysyx_22051013_regfile_mp_sb #(
        .XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .NWR(NWR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rf  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t            exp_q[$];
    int              vectors;
    int              miscompares;
    logic [3:0]      phase;
    string           phase_name [8];

    // Behavioural reference state
    logic [XLEN-1:0] regs_m [NREG];
    logic [NREG-1:0] busy_m;
    bit              known;

    // Expected outputs for the inputs currently applied and the model state.
    function automatic exp_t model_expect();
        exp_t          e;
        logic [AW-1:0] a;
        bit            hit;
        e        = '0;
        e.phase  = phase;
        e.chk_bv = known;
        e.bv     = busy_m;
        for (int j = 0; j < NRD; j++) begin
            a = bus.raddr[j*AW +: AW];
            if (!rst && bus.ren[j] && a != 0) begin
                e.rdata[j*XLEN +: XLEN] = regs_m[a];
                e.rbusy[j]              = busy_m[a];
`ifdef YSYX_22051013_RF_BYPASS_EN
                hit = 0;
                for (int k = 0; k < NWR; k++)
                    if (bus.wen[k] && bus.waddr[k*AW +: AW] == a) begin
                        e.rdata[j*XLEN +: XLEN] = bus.wdata[k*XLEN +: XLEN];
                        hit = 1;
                    end
                if (hit && !(bus.iss_en && bus.iss_rd == a)) e.rbusy[j] = 1'b0;
`else
                hit = 0;
`endif
            end
        end
        return e;
    endfunction

    // Apply the clock-edge effect of the current inputs to the model.
    task automatic model_update();
        logic [AW-1:0] a;
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_m[i] = '0;
            busy_m = '0;
            known  = 1;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                a = bus.waddr[k*AW +: AW];
                if (bus.wen[k] && a != 0) regs_m[a] = bus.wdata[k*XLEN +: XLEN];
            end
            if (bus.flush) begin
                busy_m = '0;
            end else begin
                for (int k = 0; k < NWR; k++) begin
                    a = bus.waddr[k*AW +: AW];
                    if (bus.wen[k] && a != 0) busy_m[a] = 1'b0;
                end
                if (bus.iss_en && bus.iss_rd != 0) busy_m[bus.iss_rd] = 1'b1;
            end
        end
    endtask

    // One cycle: record expectation, clock edge, move to the next drive point.
    task automatic cycle();
        exp_q.push_back(model_expect());
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.wen    = '0;
        bus.waddr  = '0;
        bus.wdata  = '0;
        bus.ren    = '0;
        bus.raddr  = '0;
        bus.iss_en = 1'b0;
        bus.iss_rd = '0;
        bus.flush  = 1'b0;
    endtask

    task automatic rd(input int j, input int a);
        bus.ren[j]            = 1'b1;
        bus.raddr[j*AW +: AW] = AW'(a);
    endtask

    task automatic wr(input int k, input int a, input logic [XLEN-1:0] d);
        bus.wen[k]                = 1'b1;
        bus.waddr[k*AW +: AW]     = AW'(a);
        bus.wdata[k*XLEN +: XLEN] = d;
    endtask

    task automatic iss(input int a);
        bus.iss_en = 1'b1;
        bus.iss_rd = AW'(a);
    endtask

    function automatic int rand_addr();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, NREG - 1));
        return int'($urandom_range(0, 7));
    endfunction

    // Monitor: outputs are always presented; sample mid-low-phase and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (bus.rdata !== e.rdata) begin
                    miscompares++;
                    $display("FAIL %s rdata: got %h expected %h", phase_name[e.phase], bus.rdata, e.rdata);
                end
                vectors++;
                if (bus.rbusy !== e.rbusy) begin
                    miscompares++;
                    $display("FAIL %s rbusy: got %b expected %b", phase_name[e.phase], bus.rbusy, e.rbusy);
                end
                if (e.chk_bv) begin
                    vectors++;
                    if (bus.busy_vec !== e.bv) begin
                        miscompares++;
                        $display("FAIL %s busy_vec: got %h expected %h", phase_name[e.phase], bus.busy_vec, e.bv);
                    end
                end
            end
        end
    end

    // Driver: directed scenarios, then random traffic.
    initial begin
        phase_name[0] = "reset";
        phase_name[1] = "read_all";
        phase_name[2] = "wr_conflict";
        phase_name[3] = "x0";
        phase_name[4] = "scoreboard";
        phase_name[5] = "flush";
        phase_name[6] = "bypass";
        phase_name[7] = "random";
        vectors     = 0;
        miscompares = 0;
        known       = 0;
        busy_m      = '0;
        for (int i = 0; i < NREG; i++) regs_m[i] = '0;
        phase = 4'd0;
        rst   = 1'b1;
        idle();
        rd(0, 1);
        rd(1, 2);
        @(negedge clk);
        cycle();
        cycle();

        rst   = 1'b0;
        phase = 4'd1;
        for (int r = 0; r < NREG; r += 2) begin
            idle();
            rd(0, r);
            rd(1, r + 1);
            cycle();
        end

        phase = 4'd2;
        idle(); wr(0, 5, 64'hA); wr(1, 5, 64'hB); rd(0, 5); cycle();
        idle(); rd(0, 5); rd(1, 5); cycle();

        phase = 4'd3;
        idle(); wr(0, 0, 64'hFFFF); iss(0); rd(0, 0); cycle();
        idle(); rd(0, 0); rd(1, 0); cycle();

        phase = 4'd4;
        idle(); iss(7); cycle();
        idle(); rd(0, 7); cycle();
        idle(); wr(0, 7, 64'h77); rd(1, 7); cycle();
        idle(); rd(0, 7); cycle();
        idle(); iss(7); cycle();
        idle(); wr(1, 7, 64'h78); iss(7); rd(0, 7); cycle();
        idle(); rd(0, 7); rd(1, 7); cycle();

        phase = 4'd5;
        idle(); iss(3); cycle();
        idle(); iss(9); rd(0, 3); cycle();
        idle(); bus.flush = 1'b1; iss(4); wr(0, 9, 64'h99); rd(0, 9); rd(1, 3); cycle();
        idle(); rd(0, 4); rd(1, 9); cycle();

        phase = 4'd6;
        idle(); wr(0, 12, 64'h1234); rd(0, 12); cycle();
        idle(); rd(0, 12); cycle();

        phase = 4'd7;
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst       = ($urandom_range(0, 63) == 0);
            bus.flush = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < NWR; k++)
                if ($urandom_range(0, 1) == 1) wr(k, rand_addr(), {$urandom(), $urandom()});
            for (int j = 0; j < NRD; j++)
                if ($urandom_range(0, 3) != 0) rd(j, rand_addr());
            if ($urandom_range(0, 1) == 1) iss(rand_addr());
            cycle();
        end
        rst = 1'b0;
        idle();

        #4;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
